// File: rtl/pool_pkg.sv
// Shared constants and types for the 2x2/stride-2 pooling window generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pool_pkg;

  localparam int POOL_K    = 2;
  localparam int POOL_SIZE = POOL_K * POOL_K;

  // Window slot order as seen by the comparator chain.
  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

  // FILL: even row, pixels go into the line buffer.
  // PAIR: odd row, pixels combine with the buffered row into windows.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    PAIR = 1'b1
  } phase_t;

  // Counter/address width with a floor of one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_window_gen_if.sv
// Pixel-in / window-out bundle between the feature-map source and the pool stage.
// Latency: n/a (wiring only).
// Backpressure: none; pixels are always accepted, windows are single-cycle pulses.
//
// Signals:
//   soft_clr   - synchronous frame abort (source -> generator)
//   pix_valid  - pix_data valid this cycle (source -> generator)
//   pix_data   - raster-order pixel (source -> generator)
//   win_data   - 2x2 window, [0]=TL [1]=TR [2]=BL [3]=BR (generator -> pool)
//   win_valid  - one-cycle window strobe (generator -> pool)
//   win_last   - final window of the frame, with win_valid (generator -> pool)
//   frame_done - one-cycle pulse after the last pixel of a frame (generator -> pool)
interface pool_window_gen_if #(
  parameter int data_width = 20
);
  import pool_pkg::*;

  logic                  soft_clr;
  logic                  pix_valid;
  logic [data_width-1:0] pix_data;
  logic [data_width-1:0] win_data [POOL_SIZE-1:0];
  logic                  win_valid;
  logic                  win_last;
  logic                  frame_done;

  // master: the pixel source / window consumer side.
  modport master (
    output soft_clr, pix_valid, pix_data,
    input  win_data, win_valid, win_last, frame_done
  );

  // slave: the window generator itself.
  modport slave (
    input  soft_clr, pix_valid, pix_data,
    output win_data, win_valid, win_last, frame_done
  );

endinterface

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single write port, two asynchronous read ports.
// Latency: reads are combinational; writes land on the next rising edge.
// Backpressure: none; a write is performed whenever wr_en is high.
//
// Ports:
//   clk                  - rising-edge clock
//   wr_en/wr_addr/wr_data- write port
//   rd_addr_a/rd_data_a  - read port A (left pixel of a window pair)
//   rd_addr_b/rd_data_b  - read port B (right pixel of a window pair)
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int data_width = 20,
  parameter int ifm_width  = 28,
  localparam int AW = clog2_min1(ifm_width)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr_a,
  output logic [data_width-1:0] rd_data_a,
  input  logic [AW-1:0]         rd_addr_b,
  output logic [data_width-1:0] rd_data_b
);

  // Contents are only meaningful after the even row has been written,
  // so the storage carries no reset.
  logic [data_width-1:0] mem [ifm_width];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2/stride-2 window generator feeding the max-pooling comparator chain.
// Latency: window registered 1 cycle after the bottom-right pixel is accepted.
// Backpressure: none; every valid pixel is accepted and windows are single-cycle pulses.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset; all outputs and counters to 0
//   bus  - slave side of pool_window_gen_if (pixel in, window out, soft_clr)
module pool_window_gen #(
  parameter int data_width = 20,
  parameter int ifm_width  = 28,
  parameter int ifm_height = 28
) (
  input logic             clk,
  input logic             rst,
  pool_window_gen_if.slave bus
);
  import pool_pkg::*;

  localparam int CW = clog2_min1(ifm_width);
  localparam int RW = clog2_min1(ifm_height);

  localparam logic [CW-1:0] COL_MAX  = CW'(ifm_width - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(ifm_height - 1);
  // Bottom-right corner of the final complete window; a trailing odd
  // row/column is never part of a window.
  localparam logic [CW-1:0] LAST_COL = CW'(POOL_K * (ifm_width / POOL_K) - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(POOL_K * (ifm_height / POOL_K) - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  phase_t                phase;
  logic [data_width-1:0] bl_reg;

  logic                  accept;
  logic                  col_end;
  logic                  row_end;
  logic                  emit;
  logic                  emit_last;
  logic                  frame_end;
  logic                  lb_wr;
  logic [CW-1:0]         lb_rd_addr_lo;
  logic [data_width-1:0] lb_rd_lo;
  logic [data_width-1:0] lb_rd_hi;

  always_comb begin
    // soft_clr drops any pixel presented in the same cycle.
    accept    = bus.pix_valid & ~bus.soft_clr;
    col_end   = (col == COL_MAX);
    row_end   = (row == ROW_MAX);
    lb_wr     = accept && (phase == FILL);
    // Only odd columns close a window, so a trailing even column in an
    // odd-width row never emits.
    emit      = accept && (phase == PAIR) && col[0];
    emit_last = emit && (col == LAST_COL) && (row == LAST_ROW);
    frame_end = accept && col_end && row_end;
    lb_rd_addr_lo = col - CW'(1);
  end

  pool_line_buffer #(
    .data_width (data_width),
    .ifm_width  (ifm_width)
  ) u_line_buf (
    .clk       (clk),
    .wr_en     (lb_wr),
    .wr_addr   (col),
    .wr_data   (bus.pix_data),
    .rd_addr_a (lb_rd_addr_lo),
    .rd_data_a (lb_rd_lo),
    .rd_addr_b (col),
    .rd_data_b (lb_rd_hi)
  );

  // Raster position and phase tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      phase  <= FILL;
      bl_reg <= '0;
    end else if (bus.soft_clr) begin
      col   <= '0;
      row   <= '0;
      phase <= FILL;
    end else if (bus.pix_valid) begin
      if ((phase == PAIR) && !col[0]) begin
        bl_reg <= bus.pix_data;
      end
      if (col_end) begin
        col <= '0;
        if (row_end) begin
          row <= '0;
        end else begin
          row <= row + RW'(1);
        end
        // An odd-height frame ends on an even row; the wrap must land in FILL.
        if (row_end || (phase == PAIR)) begin
          phase <= FILL;
        end else begin
          phase <= PAIR;
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Registered outputs; win_data holds its value between windows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.win_valid  <= 1'b0;
      bus.win_last   <= 1'b0;
      bus.frame_done <= 1'b0;
      for (int i = 0; i < POOL_SIZE; i++) begin
        bus.win_data[i] <= '0;
      end
    end else begin
      bus.win_valid  <= emit;
      bus.win_last   <= emit_last;
      bus.frame_done <= frame_end;
      if (emit) begin
        bus.win_data[WIN_TL] <= lb_rd_lo;
        bus.win_data[WIN_TR] <= lb_rd_hi;
        bus.win_data[WIN_BL] <= bl_reg;
        bus.win_data[WIN_BR] <= bus.pix_data;
      end
    end
  end

endmodule
